// File: rtl/io_input_ctrl_pkg.sv
// Shared address map, status-word layout and defaults for the pushbutton/switch input block.
package io_input_ctrl_pkg;

    localparam logic [31:0] ADDR_KEY   = 32'hF000_0010;
    localparam logic [31:0] ADDR_SW    = 32'hF000_0014;
    localparam logic [31:0] ADDR_KCTRL = 32'hF000_0110;
    localparam logic [31:0] ADDR_SCTRL = 32'hF000_0114;

    // Bit positions inside a CTRL/status word
    localparam int STAT_RDY = 0;
    localparam int STAT_OVR = 2;

    localparam int DEBOUNCE_CYCLES_DEF = 500000;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_READY = 1'b1
    } stat_state_e;

    // Packs rdy/ovr into the 3-bit status layout; unused bit 1 reads zero.
    function automatic logic [2:0] status_word(input logic rdy, input logic ovr);
        logic [2:0] w;
        w           = '0;
        w[STAT_RDY] = rdy;
        w[STAT_OVR] = ovr;
        return w;
    endfunction

endpackage

// File: rtl/io_input_ctrl_debouncer.sv
// Two-flop synchronizer plus group-wide debounce counter for a bundle of raw inputs.
// The debounced value loads the synchronized value once the group has been stable
// for DEBOUNCE_CYCLES cycles, emitting a one-cycle update pulse when it changes.
module io_debouncer #(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter logic [WIDTH-1:0] RST_VAL         = '0
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [WIDTH-1:0]                         raw_i,
    output logic [WIDTH-1:0]                         sync_o,
    output logic [$clog2(DEBOUNCE_CYCLES+1)-1:0]     cnt_o,
    output logic [WIDTH-1:0]                         db_o,
    output logic                                     upd_o
);

    localparam int              CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CMAX = CW'(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0] s1_q, s2_q, db_q, db_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             chg, upd;

    // Synchronizer, counter and debounced-value registers
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q  <= RST_VAL;
            s2_q  <= RST_VAL;
            cnt_q <= '0;
            db_q  <= RST_VAL;
        end else begin
            s1_q  <= raw_i;
            s2_q  <= s1_q;
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    // A change about to enter the synchronized stage restarts the count; the count
    // otherwise saturates, and the stable value is committed as it reaches the limit.
    always_comb begin
        chg   = (s1_q != s2_q);
        cnt_d = cnt_q;
        db_d  = db_q;
        upd   = 1'b0;
        if (chg) begin
            cnt_d = '0;
        end else if (cnt_q != CMAX) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (!chg && (cnt_q == CMAX - 1'b1) && (s2_q != db_q)) begin
            upd  = 1'b1;
            db_d = s2_q;
        end
    end

    assign sync_o = s2_q;
    assign cnt_o  = cnt_q;
    assign db_o   = db_q;
    assign upd_o  = upd;

endmodule

// File: rtl/io_input_ctrl.sv
// Memory-mapped pushbutton (KEY) and slide-switch (SW) input controller with
// per-group ready/overrun status. Loads are zero-latency; side effects land on the next edge.
module io_input_ctrl
    import io_input_ctrl_pkg::*;
#(
    parameter int DBITS           = 32,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       key_raw,
    input  logic [9:0]       sw_raw,
    input  logic [DBITS-1:0] addr,
    input  logic             rd_en,
    input  logic             wrt_en,
    input  logic [DBITS-1:0] wdata,
    output logic [DBITS-1:0] rdata,
    output logic             io_hit
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [3:0]    key_db_raw, key_db, key_sync_unused;
    logic [9:0]    sw_db, sw_sync_unused;
    logic [CW-1:0] key_cnt_unused, sw_cnt_unused;
    logic          key_upd, sw_upd;
    logic          unused_wdata;

    // Keys idle high (released), so their synchronizers reset to all-ones
    io_debouncer #(.WIDTH(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(4'hF)) u_key_db (
        .clk(clk), .reset(reset), .raw_i(key_raw),
        .sync_o(key_sync_unused), .cnt_o(key_cnt_unused), .db_o(key_db_raw), .upd_o(key_upd)
    );

    io_debouncer #(.WIDTH(10), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(10'h0)) u_sw_db (
        .clk(clk), .reset(reset), .raw_i(sw_raw),
        .sync_o(sw_sync_unused), .cnt_o(sw_cnt_unused), .db_o(sw_db), .upd_o(sw_upd)
    );

    // Software sees 1 = pressed
    assign key_db = ~key_db_raw;

    logic hit_key, hit_sw, hit_kctrl, hit_sctrl;
    assign hit_key   = (addr == DBITS'(ADDR_KEY));
    assign hit_sw    = (addr == DBITS'(ADDR_SW));
    assign hit_kctrl = (addr == DBITS'(ADDR_KCTRL));
    assign hit_sctrl = (addr == DBITS'(ADDR_SCTRL));
    assign io_hit    = hit_key | hit_sw | hit_kctrl | hit_sctrl;

    // Only bit OVR of a CTRL store carries meaning
    assign unused_wdata = ^{wdata[DBITS-1:STAT_OVR+1], wdata[STAT_OVR-1:0]};

    // Group index 0 = KEY, 1 = SW
    logic [1:0]  upd, rd_data, clr_ovr;
    assign upd     = {sw_upd, key_upd};
    assign rd_data = {rd_en & hit_sw, rd_en & hit_key};
    assign clr_ovr = {wrt_en & hit_sctrl & ~wdata[STAT_OVR], wrt_en & hit_kctrl & ~wdata[STAT_OVR]};

    stat_state_e st_q [2];
    stat_state_e st_d [2];
    logic [1:0]  ovr_q, ovr_d;

    // Status state and overrun flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q[0] <= ST_IDLE;
            st_q[1] <= ST_IDLE;
            ovr_q   <= '0;
        end else begin
            st_q[0] <= st_d[0];
            st_q[1] <= st_d[1];
            ovr_q   <= ovr_d;
        end
    end

    // Ready/overrun tracking; an update coinciding with a data read is absorbed by
    // that read (stays READY, no overrun). A new overrun wins over a same-cycle clear.
    always_comb begin
        for (int g = 0; g < 2; g++) begin
            st_d[g]  = st_q[g];
            ovr_d[g] = ovr_q[g];
            if (clr_ovr[g]) ovr_d[g] = 1'b0;
            case (st_q[g])
                ST_IDLE: begin
                    if (upd[g]) st_d[g] = ST_READY;
                end
                ST_READY: begin
                    if (upd[g] && !rd_data[g])      ovr_d[g] = 1'b1;
                    else if (rd_data[g] && !upd[g]) st_d[g]  = ST_IDLE;
                end
                default: st_d[g] = ST_IDLE;
            endcase
        end
    end

    // Read mux; all readable state is zero while reset is held
    always_comb begin
        rdata = '0;
        if (!reset) begin
            if (hit_key)        rdata = DBITS'(key_db);
            else if (hit_sw)    rdata = DBITS'(sw_db);
            else if (hit_kctrl) rdata = DBITS'(status_word(st_q[0] == ST_READY, ovr_q[0]));
            else if (hit_sctrl) rdata = DBITS'(status_word(st_q[1] == ST_READY, ovr_q[1]));
        end
    end

endmodule

// File: tb/tb_io_input_ctrl.sv
// Scoreboard bench: stimulus queues expected load results, a monitor compares them.
module tb_io_input_ctrl;
    import io_input_ctrl_pkg::*;

    localparam logic [31:0] ADDR_BAD = 32'hF000_0018;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  key_raw = 4'hF;
    logic [9:0]  sw_raw = 10'h0;
    logic [31:0] addr = '0;
    logic        rd_en = 1'b0;
    logic        wrt_en = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        io_hit;

    int   checks = 0;
    int   errors = 0;
    logic mon_vld = 1'b0;

    logic [31:0] exp_q [$];
    logic        exp_hit_q [$];
    string       tag_q [$];

    always #5 clk = ~clk;

    io_input_ctrl #(.DBITS(32), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .key_raw(key_raw), .sw_raw(sw_raw),
        .addr(addr), .rd_en(rd_en), .wrt_en(wrt_en), .wdata(wdata),
        .rdata(rdata), .io_hit(io_hit)
    );

    // One bus cycle, driven at the falling edge; optionally queue an expectation
    task automatic step(input logic [31:0] a, input logic rd, input logic wr,
                        input logic [31:0] wd, input logic chk,
                        input logic [31:0] ed, input logic eh, input string tag);
        @(negedge clk);
        addr    = a;
        rd_en   = rd;
        wrt_en  = wr;
        wdata   = wd;
        mon_vld = chk;
        if (chk) begin
            exp_q.push_back(ed);
            exp_hit_q.push_back(eh);
            tag_q.push_back(tag);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "");
    endtask

    task automatic chk(input logic [31:0] a, input logic [31:0] ed, input logic eh, input string tag);
        step(a, 1'b0, 1'b0, 32'h0, 1'b1, ed, eh, tag);
    endtask

    task automatic ld(input logic [31:0] a, input logic [31:0] ed, input logic eh, input string tag);
        step(a, 1'b1, 1'b0, 32'h0, 1'b1, ed, eh, tag);
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] wd);
        step(a, 1'b0, 1'b1, wd, 1'b0, 32'h0, 1'b0, "");
    endtask

    // Monitor: compares shortly after each falling edge where a check was issued
    always @(negedge clk) begin : monitor
        logic [31:0] ed;
        logic        eh;
        string       t;
        #1;
        if (mon_vld) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: output presented with no expectation queued");
            end else begin
                ed = exp_q.pop_front();
                eh = exp_hit_q.pop_front();
                t  = tag_q.pop_front();
                if (rdata !== ed || io_hit !== eh) begin
                    errors++;
                    $display("FAIL %s: got rdata=%h io_hit=%b, expected rdata=%h io_hit=%b",
                             t, rdata, io_hit, ed, eh);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        // Reset: reads return zero while reset is held
        chk(ADDR_KEY, 32'h0, 1'b1, "rst_hold_key");
        chk(ADDR_KCTRL, 32'h0, 1'b1, "rst_hold_kctrl");
        reset = 1'b0;
        idle(8);
        chk(ADDR_KEY,   32'h0, 1'b1, "rst_key");
        chk(ADDR_SW,    32'h0, 1'b1, "rst_sw");
        chk(ADDR_KCTRL, 32'h0, 1'b1, "rst_kctrl");
        chk(ADDR_SCTRL, 32'h0, 1'b1, "rst_sctrl");

        // Press KEY0: qualifies on the 6th rising edge after the change
        key_raw = 4'hE;
        idle(4);
        chk(ADDR_KEY,   32'h0, 1'b1, "key_not_yet");
        chk(ADDR_KEY,   32'h1, 1'b1, "key_pressed");
        chk(ADDR_KCTRL, 32'h1, 1'b1, "kctrl_ready");
        ld(ADDR_KEY,    32'h1, 1'b1, "key_load");
        chk(ADDR_KCTRL, 32'h0, 1'b1, "kctrl_after_load");
        key_raw = 4'hF;
        idle(8);
        ld(ADDR_KEY,    32'h0, 1'b1, "key_release_load");
        chk(ADDR_KCTRL, 32'h0, 1'b1, "kctrl_after_release");

        // SW bit3 bouncing every 2 cycles never qualifies
        for (int i = 0; i < 10; i++) begin
            sw_raw = (i % 2 == 0) ? 10'h008 : 10'h000;
            idle(1);
            chk(ADDR_SW, 32'h0, 1'b1, "sw_bounce");
        end
        sw_raw = 10'h008;
        chk(ADDR_SCTRL, 32'h0, 1'b1, "sctrl_bounce_idle");
        idle(8);
        chk(ADDR_SW,    32'h8, 1'b1, "sw_settled");
        chk(ADDR_SCTRL, 32'h1, 1'b1, "sctrl_settled");

        // Two updates without a read -> overrun; CTRL store semantics
        ld(ADDR_SW,     32'h8, 1'b1, "sw_load_8");
        chk(ADDR_SCTRL, 32'h0, 1'b1, "sctrl_idle");
        sw_raw = 10'h001;
        idle(8);
        chk(ADDR_SCTRL, 32'h1, 1'b1, "sctrl_first_upd");
        sw_raw = 10'h002;
        idle(8);
        chk(ADDR_SCTRL, 32'h5, 1'b1, "sctrl_overrun");
        st(ADDR_SCTRL, 32'h4);
        chk(ADDR_SCTRL, 32'h5, 1'b1, "sctrl_keep_ovr");
        st(ADDR_SCTRL, 32'h0);
        chk(ADDR_SCTRL, 32'h1, 1'b1, "sctrl_clr_ovr");
        ld(ADDR_SW,     32'h2, 1'b1, "sw_load_2");
        chk(ADDR_SCTRL, 32'h0, 1'b1, "sctrl_after_load");

        // Load coinciding with an update while READY
        sw_raw = 10'h003;
        idle(8);
        chk(ADDR_SCTRL, 32'h1, 1'b1, "sctrl_ready_3");
        sw_raw = 10'h007;
        idle(4);
        ld(ADDR_SW,     32'h3, 1'b1, "sw_load_same_cycle_old");
        chk(ADDR_SCTRL, 32'h1, 1'b1, "sctrl_same_cycle");
        chk(ADDR_SW,    32'h7, 1'b1, "sw_new_value");
        ld(ADDR_SW,     32'h7, 1'b1, "sw_load_7");
        chk(ADDR_SCTRL, 32'h0, 1'b1, "sctrl_after_load_7");

        // Reset mid-debounce (counter at 2) discards the pending press
        key_raw = 4'hE;
        idle(4);
        reset = 1'b1;
        chk(ADDR_SW, 32'h0, 1'b1, "rst_mid_sw");
        reset = 1'b0;
        idle(4);
        chk(ADDR_KEY, 32'h0, 1'b1, "key_after_rst_pending");
        chk(ADDR_KEY, 32'h1, 1'b1, "key_after_rst_qual");

        // Unmapped address, ignored data store, side-effect-free CTRL load
        ld(ADDR_BAD, 32'h0, 1'b0, "unmapped_load");
        st(ADDR_KEY, 32'hFFFF_FFFF);
        chk(ADDR_KEY,   32'h1, 1'b1, "key_after_store");
        ld(ADDR_KCTRL,  32'h1, 1'b1, "kctrl_load");
        chk(ADDR_KCTRL, 32'h1, 1'b1, "kctrl_after_ctrl_load");
        st(ADDR_KCTRL, 32'hFFFF_FFFF);
        chk(ADDR_KCTRL, 32'h1, 1'b1, "kctrl_rdy_readonly");

        idle(2);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d expectations never compared, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
